// File: rtl/enc8b10b_framer.sv
// 8b/10b packet framer: preamble, encoded payload, K23.7, optional CRC-32, K28.5.
// Running disparity persists across packets; every output is registered.
module enc8b10b_framer #(
    parameter int PREAMBLE_LEN = 4,
    parameter int CRC_EN       = 1,
    parameter int LSB_FIRST    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pushin,
    input  logic [8:0] datain,
    input  logic       startin,
    input  logic       endin,
    output logic       readyout,
    output logic       pushout,
    output logic [9:0] dataout,
    output logic       startout,
    output logic       endout,
    output logic       errout
);

    typedef enum logic [2:0] {IDLE, PRE, DATA, EOP, CRC, SOF_END} state_t;

    localparam logic [8:0] K281 = 9'h13C;
    localparam logic [8:0] K285 = 9'h1BC;
    localparam logic [8:0] K237 = 9'h1F7;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [8:0]  hold_q;
    logic        hold_end_q;
    logic        rd_q;
    logic [31:0] crc_q;
    logic        rdy_q;

    logic        accept, drop, pre_done;
    logic [7:0]  crc_b;
    logic [8:0]  sel_d, enc_in_d;
    logic        kbad_d;
    logic [10:0] enc_d;
    logic [9:0]  dout_d;

    // Returns {rd_out, abcdei, fghj}; bit 9 of the symbol is code bit a.
    function automatic logic [10:0] enc(input logic k, input logic [7:0] b, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] s6;
        logic [3:0] s4;
        logic       rd6;
        logic       a7;
        x = b[4:0];
        y = b[7:5];
        case (x)
            5'd0:  s6 = 6'b100111;  5'd1:  s6 = 6'b011101;
            5'd2:  s6 = 6'b101101;  5'd3:  s6 = 6'b110001;
            5'd4:  s6 = 6'b110101;  5'd5:  s6 = 6'b101001;
            5'd6:  s6 = 6'b011001;  5'd7:  s6 = 6'b111000;
            5'd8:  s6 = 6'b111001;  5'd9:  s6 = 6'b100101;
            5'd10: s6 = 6'b010101;  5'd11: s6 = 6'b110100;
            5'd12: s6 = 6'b001101;  5'd13: s6 = 6'b101100;
            5'd14: s6 = 6'b011100;  5'd15: s6 = 6'b010111;
            5'd16: s6 = 6'b011011;  5'd17: s6 = 6'b100011;
            5'd18: s6 = 6'b010011;  5'd19: s6 = 6'b110010;
            5'd20: s6 = 6'b001011;  5'd21: s6 = 6'b101010;
            5'd22: s6 = 6'b011010;  5'd23: s6 = 6'b111010;
            5'd24: s6 = 6'b110011;  5'd25: s6 = 6'b100110;
            5'd26: s6 = 6'b010110;  5'd27: s6 = 6'b110110;
            5'd28: s6 = 6'b001110;  5'd29: s6 = 6'b101110;
            5'd30: s6 = 6'b011110;  default: s6 = 6'b101011;
        endcase
        if (k && x == 5'd28) s6 = 6'b001111;
        if (rd && (($countones(s6) != 3) || x == 5'd7)) s6 = ~s6;
        rd6 = ($countones(s6) != 3) ? ~rd : rd;
        case (y)
            3'd0:    s4 = 4'b1011;
            3'd1:    s4 = 4'b1001;
            3'd2:    s4 = 4'b0101;
            3'd3:    s4 = 4'b1100;
            3'd4:    s4 = 4'b1101;
            3'd5:    s4 = 4'b1010;
            3'd6:    s4 = 4'b0110;
            default: s4 = 4'b1110;
        endcase
        a7 = (y == 3'd7) &&
             (k || (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                   (rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        if (a7) s4 = 4'b0111;
        // Control symbols invert the neutral 3b/4b codes so commas stay unique.
        if (k) begin
            if (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6) s4 = ~s4;
            if (rd6) s4 = ~s4;
        end else if (rd6 && (($countones(s4) != 2) || y == 3'd3)) begin
            s4 = ~s4;
        end
        return {(($countones(s4) != 2) ? ~rd6 : rd6), s6, s4};
    endfunction

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign accept   = pushin & readyout;
    assign drop     = pushin & ~readyout;
    assign pre_done = (cnt_q == 4'(PREAMBLE_LEN));
    assign readyout = rdy_q & ~reset;

    // Pick the byte the current state wants to emit and encode it.
    always_comb begin
        case (cnt_q[1:0])
            2'd0:    crc_b = ~crc_q[7:0];
            2'd1:    crc_b = ~crc_q[15:8];
            2'd2:    crc_b = ~crc_q[23:16];
            default: crc_b = ~crc_q[31:24];
        endcase
        case (state_q)
            PRE:     sel_d = pre_done ? hold_q : K281;
            DATA:    sel_d = datain;
            EOP:     sel_d = K237;
            CRC:     sel_d = {1'b0, crc_b};
            default: sel_d = K285;
        endcase
        kbad_d = sel_d[8] && !(sel_d[4:0] == 5'd28 ||
                 (sel_d[7:5] == 3'd7 && (sel_d[4:0] == 5'd23 || sel_d[4:0] == 5'd27 ||
                                         sel_d[4:0] == 5'd29 || sel_d[4:0] == 5'd30)));
        enc_in_d = kbad_d ? K285 : sel_d;
        enc_d    = enc(enc_in_d[8], enc_in_d[7:0], rd_q);
        dout_d   = '0;
        for (int i = 0; i < 10; i++) dout_d[i] = (LSB_FIRST != 0) ? enc_d[9-i] : enc_d[i];
    end

    // Framing FSM with registered outputs, disparity and CRC state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hold_q     <= '0;
            hold_end_q <= 1'b0;
            rd_q       <= 1'b0;
            crc_q      <= 32'hFFFFFFFF;
            rdy_q      <= 1'b1;
            pushout    <= 1'b0;
            dataout    <= '0;
            startout   <= 1'b0;
            endout     <= 1'b0;
            errout     <= 1'b0;
        end else begin
            pushout  <= 1'b0;
            startout <= 1'b0;
            endout   <= 1'b0;
            errout   <= drop;
            case (state_q)
                IDLE: begin
                    if (accept && startin) begin
                        hold_q     <= datain;
                        hold_end_q <= endin;
                        crc_q      <= 32'hFFFFFFFF;
                        cnt_q      <= '0;
                        rdy_q      <= 1'b0;
                        state_q    <= PRE;
                    end else if (accept) begin
                        errout <= 1'b1;
                    end
                end
                PRE: begin
                    pushout <= 1'b1;
                    dataout <= dout_d;
                    rd_q    <= enc_d[10];
                    if (!pre_done) begin
                        startout <= (cnt_q == 4'd0);
                        cnt_q    <= cnt_q + 4'd1;
                    end else begin
                        cnt_q  <= '0;
                        errout <= drop | kbad_d;
                        if (!hold_q[8]) crc_q <= crc_upd(crc_q, hold_q[7:0]);
                        rdy_q   <= ~hold_end_q;
                        state_q <= hold_end_q ? EOP : DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        pushout <= 1'b1;
                        dataout <= dout_d;
                        rd_q    <= enc_d[10];
                        errout  <= kbad_d | startin;
                        if (!datain[8]) crc_q <= crc_upd(crc_q, datain[7:0]);
                        if (endin) begin
                            rdy_q   <= 1'b0;
                            state_q <= EOP;
                        end
                    end
                end
                EOP: begin
                    pushout <= 1'b1;
                    dataout <= dout_d;
                    rd_q    <= enc_d[10];
                    cnt_q   <= '0;
                    state_q <= (CRC_EN != 0) ? CRC : SOF_END;
                end
                CRC: begin
                    pushout <= 1'b1;
                    dataout <= dout_d;
                    rd_q    <= enc_d[10];
                    cnt_q   <= cnt_q + 4'd1;
                    if (cnt_q[1:0] == 2'd3) begin
                        cnt_q   <= '0;
                        state_q <= SOF_END;
                    end
                end
                default: begin
                    pushout <= 1'b1;
                    dataout <= dout_d;
                    rd_q    <= enc_d[10];
                    endout  <= 1'b1;
                    rdy_q   <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc8b10b_framer.sv
// Directed bench for enc8b10b_framer: default instance plus a short,
// CRC-less instance; symbols are hand-encoded in abcdei fghj order.
module tb_enc8b10b_framer;

    logic       clk = 1'b0;
    logic       reset;
    logic       pushin, startin, endin;
    logic [8:0] datain;
    logic       readyout, pushout, startout, endout, errout;
    logic [9:0] dataout;
    logic       pushin2, startin2, endin2;
    logic [8:0] datain2;
    logic       readyout2, pushout2, startout2, endout2, errout2;
    logic [9:0] dataout2;

    int checks = 0;
    int failures = 0;
    int err1 = 0;
    int err2 = 0;
    int b, e0, b3;
    logic [11:0] q1[$];
    logic [11:0] q2[$];

    localparam logic [9:0] E1 [11] = '{
        10'b0011111001, 10'b1100000110, 10'b0011111001, 10'b1100000110,
        10'b1001110100, 10'b1110101000, 10'b1011001101, 10'b1010001110,
        10'b0100101011, 10'b0100110110, 10'b1100000101};
    localparam logic [9:0] E2 [14] = '{
        10'b0011111001, 10'b1100000110, 10'b0011111001, 10'b1100000110,
        10'b0111010011, 10'b0100101100, 10'b0011111010, 10'b1100010011,
        10'b0001010111, 10'b0100100110, 10'b0111010101, 10'b0010101001,
        10'b1010101001, 10'b0011111010};
    localparam logic [9:0] E3 [6] = '{
        10'b0011111001, 10'b1010101010, 10'b1100010100,
        10'b1010101010, 10'b1110101000, 10'b0011111010};

    always #5 clk = ~clk;

    enc8b10b_framer u_dut (
        .clk(clk), .reset(reset), .pushin(pushin), .datain(datain),
        .startin(startin), .endin(endin), .readyout(readyout),
        .pushout(pushout), .dataout(dataout), .startout(startout),
        .endout(endout), .errout(errout));

    enc8b10b_framer #(.PREAMBLE_LEN(1), .CRC_EN(0), .LSB_FIRST(1)) u_dut2 (
        .clk(clk), .reset(reset), .pushin(pushin2), .datain(datain2),
        .startin(startin2), .endin(endin2), .readyout(readyout2),
        .pushout(pushout2), .dataout(dataout2), .startout(startout2),
        .endout(endout2), .errout(errout2));

    // Collect emitted symbols and error-pulse cycles away from the rising edge.
    always @(negedge clk) begin
        if (pushout) q1.push_back({startout, endout, dataout});
        if (pushout2) q2.push_back({startout2, endout2, dataout2});
        if (errout) err1++;
        if (errout2) err2++;
    end

    function automatic logic [9:0] rev10(input logic [9:0] x);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = x[9-i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_sym(input string tag, input logic [11:0] got,
                           input logic [9:0] code, input logic s, input logic e);
        chk(tag, {20'd0, got}, {20'd0, s, e, rev10(code)});
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push1(input logic [8:0] d, input logic s, input logic e);
        int n;
        n = 0;
        while (!readyout && n < 50) begin step(); n++; end
        chk("rdy1_wait", {31'd0, readyout}, 32'd1);
        pushin = 1'b1; datain = d; startin = s; endin = e;
        step();
        pushin = 1'b0; datain = '0; startin = 1'b0; endin = 1'b0;
    endtask

    task automatic push2(input logic [8:0] d, input logic s, input logic e);
        int n;
        n = 0;
        while (!readyout2 && n < 50) begin step(); n++; end
        chk("rdy2_wait", {31'd0, readyout2}, 32'd1);
        pushin2 = 1'b1; datain2 = d; startin2 = s; endin2 = e;
        step();
        pushin2 = 1'b0; datain2 = '0; startin2 = 1'b0; endin2 = 1'b0;
    endtask

    task automatic wait_q1(input int n);
        int t;
        t = 0;
        while (q1.size() < n && t < 200) begin step(); t++; end
        chk("q1_wait", q1.size(), n);
    endtask

    initial begin
        reset = 1'b1;
        pushin = 1'b0; datain = '0; startin = 1'b0; endin = 1'b0;
        pushin2 = 1'b0; datain2 = '0; startin2 = 1'b0; endin2 = 1'b0;
        step(); step();
        chk("rst_ready", {31'd0, readyout}, 32'd0);
        chk("rst_push", {31'd0, pushout}, 32'd0);
        chk("rst_data", {22'd0, dataout}, 32'd0);
        chk("rst_flags", {29'd0, startout, endout, errout}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_ready", {31'd0, readyout}, 32'd1);

        // Single zero byte, start and end together.
        b = q1.size(); e0 = err1;
        push1(9'h000, 1'b1, 1'b1);
        wait_q1(b + 11);
        step(); step(); step();
        chk("p1_len", q1.size() - b, 11);
        for (int i = 0; i < 11; i++)
            chk_sym($sformatf("p1_sym%0d", i), q1[b+i], E1[i], i == 0, i == 10);
        chk("p1_err", err1 - e0, 0);
        chk("p1_idle_ready", {31'd0, readyout}, 32'd1);

        // "abc" with drops, a startin-in-data byte, an illegal K and an idle gap.
        b = q1.size(); e0 = err1;
        push1(9'h061, 1'b1, 1'b0);
        pushin = 1'b1; datain = 9'h0AA;
        step();
        pushin = 1'b0; datain = '0;
        push1(9'h062, 1'b1, 1'b0);
        push1(9'h1FF, 1'b0, 1'b0);
        step();
        push1(9'h063, 1'b0, 1'b1);
        wait_q1(b + 10);
        pushin = 1'b1; datain = 9'h055;
        step();
        pushin = 1'b0; datain = '0;
        wait_q1(b + 14);
        step(); step(); step();
        chk("p2_len", q1.size() - b, 14);
        for (int i = 0; i < 14; i++)
            chk_sym($sformatf("p2_sym%0d", i), q1[b+i], E2[i], i == 0, i == 13);
        chk("p2_err", err1 - e0, 4);

        // Abort during the second CRC symbol.
        b3 = q1.size();
        push1(9'h000, 1'b1, 1'b1);
        wait_q1(b3 + 8);
        reset = 1'b1;
        #1;
        chk("abort_push", {31'd0, pushout}, 32'd0);
        chk("abort_ready", {31'd0, readyout}, 32'd0);
        chk_sym("p3_first", q1[b3], 10'b1100000110, 1'b1, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk("abort_len", q1.size() - b3, 8);
        chk("abort_rel_ready", {31'd0, readyout}, 32'd1);
        b = q1.size(); e0 = err1;
        push1(9'h000, 1'b1, 1'b1);
        wait_q1(b + 11);
        step(); step();
        chk("p4_len", q1.size() - b, 11);
        for (int i = 0; i < 11; i++)
            chk_sym($sformatf("p4_sym%0d", i), q1[b+i], E1[i], i == 0, i == 10);
        chk("p4_err", err1 - e0, 0);

        // Short preamble, no CRC, D21.5 at both disparities.
        b = q2.size(); e0 = err2;
        push2(9'h0B5, 1'b1, 1'b0);
        push2(9'h003, 1'b0, 1'b0);
        push2(9'h0B5, 1'b0, 1'b1);
        for (int t = 0; t < 30 && q2.size() < b + 6; t++) step();
        step(); step();
        chk("q2_len", q2.size() - b, 6);
        for (int i = 0; i < 6; i++)
            chk_sym($sformatf("q2_sym%0d", i), q2[b+i], E3[i], i == 0, i == 5);
        chk("q2_err", err2 - e0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
